// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
package axi_arb_pkg;

    localparam int MAX_MASTERS = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arb_core.sv
// Combinational winner select: round robin from ptr, or lowest index first
// when AXI_ARB_FIXED_PRIO_EN is defined.
module rr_arb_core #(
    parameter int N         = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    logic [IDX_WIDTH-1:0] lo_idx;
    logic [IDX_WIDTH-1:0] hi_idx;
    logic                 hi_any;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IDX_WIDTH'(j);
            end
            if (req[j] && (IDX_WIDTH'(j) >= ptr)) begin
                hi_idx = IDX_WIDTH'(j);
                hi_any = 1'b1;
            end
        end
    end

`ifdef AXI_ARB_FIXED_PRIO_EN
    logic ptr_unused;
    logic hi_unused;
    assign ptr_unused = ^ptr;
    assign hi_unused  = hi_any ^ (^hi_idx);
    assign idx        = lo_idx;
`else
    assign idx = hi_any ? hi_idx : lo_idx;
`endif

    assign any = |req;

    always_comb begin
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = any && (idx == IDX_WIDTH'(j));
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to one-slave AXI4-Lite arbiter, one transaction in flight at a time.
// Optional build macro: AXI_ARB_FIXED_PRIO_EN (fixed priority, lowest index wins).
module axi_lite_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                axi_aclk,
    input  logic                                axi_aresetn,

    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [NUM_MASTERS*3-1:0]            s_awprot,
    input  logic [NUM_MASTERS-1:0]              s_awvalid,
    output logic [NUM_MASTERS-1:0]              s_awready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   s_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_MASTERS-1:0]              s_wvalid,
    output logic [NUM_MASTERS-1:0]              s_wready,
    output logic [1:0]                          s_bresp,
    output logic [NUM_MASTERS-1:0]              s_bvalid,
    input  logic [NUM_MASTERS-1:0]              s_bready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   s_araddr,
    input  logic [NUM_MASTERS*3-1:0]            s_arprot,
    input  logic [NUM_MASTERS-1:0]              s_arvalid,
    output logic [NUM_MASTERS-1:0]              s_arready,
    output logic [DATA_WIDTH-1:0]               s_rdata,
    output logic [1:0]                          s_rresp,
    output logic [NUM_MASTERS-1:0]              s_rvalid,
    input  logic [NUM_MASTERS-1:0]              s_rready,

    output logic [ADDR_WIDTH-1:0]               m_awaddr,
    output logic [2:0]                          m_awprot,
    output logic                                m_awvalid,
    input  logic                                m_awready,
    output logic [DATA_WIDTH-1:0]               m_wdata,
    output logic [DATA_WIDTH/8-1:0]             m_wstrb,
    output logic                                m_wvalid,
    input  logic                                m_wready,
    input  logic [1:0]                          m_bresp,
    input  logic                                m_bvalid,
    output logic                                m_bready,
    output logic [ADDR_WIDTH-1:0]               m_araddr,
    output logic [2:0]                          m_arprot,
    output logic                                m_arvalid,
    input  logic                                m_arready,
    input  logic [DATA_WIDTH-1:0]               m_rdata,
    input  logic [1:0]                          m_rresp,
    input  logic                                m_rvalid,
    output logic                                m_rready,

    output logic [IDX_WIDTH-1:0]                grant_idx
);

    arb_state_e state_q, state_d;
    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d, ptr_after;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] req, win_gnt;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic                   win_any, win_awvalid;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic aw_hs, w_hs;

    assign req         = s_awvalid | s_arvalid;
    assign win_awvalid = |(win_gnt & s_awvalid);

    rr_arb_core #(
        .N         (NUM_MASTERS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_core (
        .req (req),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // Payload and per-master handshake selection for the registered owner.
    always_comb begin
        m_awaddr  = '0;
        m_awprot  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_araddr  = '0;
        m_arprot  = '0;
        g_awvalid = 1'b0;
        g_wvalid  = 1'b0;
        g_bready  = 1'b0;
        g_arvalid = 1'b0;
        g_rready  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_WIDTH'(i) == grant_q) begin
                m_awaddr  = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_awprot  = s_awprot[i*3 +: 3];
                m_wdata   = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_wstrb   = s_wstrb[i*(DATA_WIDTH/8) +: DATA_WIDTH/8];
                m_araddr  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_arprot  = s_arprot[i*3 +: 3];
                g_awvalid = s_awvalid[i];
                g_wvalid  = s_wvalid[i];
                g_bready  = s_bready[i];
                g_arvalid = s_arvalid[i];
                g_rready  = s_rready[i];
            end
        end
    end

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign ptr_after = '0;
`else
    assign ptr_after = (grant_q == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        s_bresp   = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    grant_d = win_idx;
                    state_d = win_awvalid ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                m_awvalid          = g_awvalid & ~aw_done_q;
                m_wvalid           = g_wvalid & ~w_done_q;
                s_awready[grant_q] = m_awready & ~aw_done_q;
                s_wready[grant_q]  = m_wready & ~w_done_q;
                aw_hs              = m_awvalid & m_awready;
                w_hs               = m_wvalid & m_wready;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = g_bready;
                s_bresp           = m_bresp;
                if (m_bvalid && g_bready) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end
            end
            RD_REQ: begin
                m_arvalid          = g_arvalid;
                s_arready[grant_q] = m_arready;
                if (g_arvalid && m_arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s_rvalid[grant_q] = m_rvalid;
                m_rready          = g_rready;
                s_rdata           = m_rdata;
                s_rresp           = m_rresp;
                if (m_rvalid && g_rready) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant_idx = grant_q;

endmodule
